// File: rtl/imem_pkg.sv
// Shared instruction-memory definitions: geometry, loader states and the word type
// used by the loader, the instruction memory and the IF/ID register.
package imem_pkg;

  localparam int IMEM_ADDR_W = 5;
  localparam int IMEM_DEPTH  = 32;
  localparam int WORD_BYTES  = 4;

  typedef logic [31:0] instr_word_t;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    DATA,
    WRITE,
    CHK,
    DONE,
    ERR
  } loaderState_e;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Big-endian byte packer for the instruction loader: the first byte of a group
// lands in word[31:24], and lastByte flags the byte that completes the word.
module byte_packer
  import imem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        shiftEn,
  input  logic [7:0]  inByte,
  output instr_word_t word,
  output logic        lastByte
);

  logic [1:0] byteCnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byteCnt <= 2'd0;
    end else if (clear) begin
      byteCnt <= 2'd0;
    end else if (shiftEn) begin
      byteCnt <= byteCnt + 2'd1;
    end
  end

  // Data register is left unreset; a partial word is discarded through byteCnt.
  always_ff @(posedge clk) begin
    if (shiftEn) begin
      word <= {word[23:0], inByte};
    end
  end

  assign lastByte = shiftEn && (byteCnt == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader for the instruction memory; holds cpu_run low until
// a frame completes. Define IMEM_LOADER_CHECKSUM_EN for a trailing XOR checksum byte.
module imem_loader
  import imem_pkg::*;
#(
  parameter int ADDR_W     = IMEM_ADDR_W,
  parameter int DEPTH      = IMEM_DEPTH,
  parameter int WORD_BYTES = imem_pkg::WORD_BYTES
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_start,
  input  logic                    in_valid,
  input  logic [7:0]              in_byte,
  output logic                    in_ready,
  output logic                    wr_en,
  output logic [ADDR_W-1:0]       wr_addr,
  output logic [8*WORD_BYTES-1:0] wr_data,
  output logic                    cpu_run,
  output logic                    done,
  output logic                    error
);

  localparam logic [7:0]        DEPTH_B  = 8'(DEPTH);
  localparam logic [ADDR_W:0]   DEPTH_W  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  loaderState_e      state, stateNxt;
  logic [ADDR_W:0]   wordsTotal;
  logic [ADDR_W-1:0] wordCnt;
  logic              cpuRunQ, doneQ, errorQ;
  logic              accept, lastWord, packLast;
  logic [ADDR_W:0]   hdrCount;
  instr_word_t       packWord;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        chkXor;
`endif

  assign accept   = in_valid && in_ready;
  assign hdrCount = (in_byte == 8'd0) ? DEPTH_W : in_byte[ADDR_W:0];
  assign lastWord = (({1'b0, wordCnt} + CNT_ONE) == wordsTotal);

  byte_packer uPacker (
    .clk      (clk),
    .rst      (rst),
    .clear    (state == IDLE),
    .shiftEn  (accept && (state == DATA)),
    .inByte   (in_byte),
    .word     (packWord),
    .lastByte (packLast)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= stateNxt;
    end
  end

  always_comb begin
    stateNxt = state;
    unique case (state)
      IDLE:  if (load_start) stateNxt = HDR;
      HDR:   if (accept) stateNxt = (in_byte > DEPTH_B) ? ERR : DATA;
      DATA:  if (packLast) stateNxt = WRITE;
`ifdef IMEM_LOADER_CHECKSUM_EN
      WRITE: stateNxt = lastWord ? CHK : DATA;
      CHK:   if (accept) stateNxt = (in_byte == chkXor) ? DONE : ERR;
`else
      WRITE: stateNxt = lastWord ? DONE : DATA;
`endif
      DONE:  stateNxt = IDLE;
      ERR:   stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  // Status flags update one edge after DONE/ERR is entered and then hold in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wordsTotal <= '0;
      wordCnt    <= '0;
      cpuRunQ    <= 1'b0;
      doneQ      <= 1'b0;
      errorQ     <= 1'b0;
    end else begin
      if ((state == IDLE) && load_start) begin
        wordCnt <= '0;
        cpuRunQ <= 1'b0;
        doneQ   <= 1'b0;
        errorQ  <= 1'b0;
      end
      if ((state == HDR) && accept) wordsTotal <= hdrCount;
      if (state == WRITE) wordCnt <= wordCnt + ADDR_ONE;
      if (state == DONE) begin
        doneQ   <= 1'b1;
        cpuRunQ <= 1'b1;
      end
      if (state == ERR) begin
        errorQ  <= 1'b1;
        cpuRunQ <= 1'b0;
      end
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chkXor <= 8'd0;
    end else if ((state == IDLE) && load_start) begin
      chkXor <= 8'd0;
    end else if ((state == DATA) && accept) begin
      chkXor <= chkXor ^ in_byte;
    end
  end
`endif

  assign in_ready = (state == HDR) || (state == DATA) || (state == CHK);
  assign wr_en    = (state == WRITE);
  assign wr_addr  = wr_en ? wordCnt : '0;
  assign wr_data  = wr_en ? packWord : '0;
  assign cpu_run  = cpuRunQ;
  assign done     = doneQ;
  assign error    = errorQ;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued as bytes are driven
// and checked when wr_en fires. Define IMEM_LOADER_CHECKSUM_EN to exercise the checksum.
module tb_imem_loader;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wrExp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_start;
  logic        in_valid;
  logic [7:0]  in_byte;
  logic        in_ready;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        cpu_run;
  logic        done;
  logic        error;

  wrExp_t      sb[$];
  wrExp_t      monExp;
  logic [31:0] words[$];
  int          nVec = 0;
  int          nMis = 0;

  always #5 clk = ~clk;

  imem_loader dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .in_valid   (in_valid),
    .in_byte    (in_byte),
    .in_ready   (in_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .cpu_run    (cpu_run),
    .done       (done),
    .error      (error)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nVec++;
    if (obs !== exp) begin
      nMis++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      chk("wrRdy", {31'd0, in_ready}, 32'd0);
      if (sb.size() == 0) begin
        chk("wrSpurious", {27'd0, wr_addr}, 32'hFFFF_FFFF);
      end else begin
        monExp = sb.pop_front();
        chk("wrAddr", {27'd0, wr_addr}, {27'd0, monExp.addr});
        chk("wrData", wr_data, monExp.data);
      end
    end
  end

  task automatic sendByte(input logic [7:0] b, input bit gap);
    logic rdy;
    int   n;
    rdy = 1'b0;
    n   = 0;
    if (gap) begin
      in_valid = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_byte  = b;
    do begin
      rdy = in_ready;
      @(negedge clk);
      n++;
    end while (!rdy && n < 40);
    in_valid = 1'b0;
    in_byte  = 8'h00;
    if (!rdy) chk("rdyTimeout", 32'd0, 32'd1);
  endtask

  task automatic startFrame();
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  task automatic runFrame(input logic [7:0] cnt, input bit gap, input bit badChk, input bit expOk);
    logic [7:0] x;
    logic [7:0] b;
    x = 8'h00;
    startFrame();
    chk("errClr", {31'd0, error}, 32'd0);
    chk("doneClr", {31'd0, done}, 32'd0);
    chk("runClr", {31'd0, cpu_run}, 32'd0);
    sendByte(cnt, gap);
    for (int w = 0; w < words.size(); w++) begin
      sb.push_back('{w[4:0], words[w]});
      for (int j = 0; j < 4; j++) begin
        b = words[w][31-8*j -: 8];
        x = x ^ b;
        sendByte(b, gap);
      end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    sendByte(badChk ? (x ^ 8'h01) : x, gap);
`else
    chk("wrEnLat", {31'd0, wr_en}, 32'd1);
    chk("rdyInWrite", {31'd0, in_ready}, 32'd0);
    chk("doneEarly", {31'd0, done}, 32'd0);
    @(negedge clk);
`endif
    chk("doneLat", {31'd0, done}, 32'd0);
    @(negedge clk);
    chk("done", {31'd0, done}, {31'd0, expOk});
    chk("cpuRun", {31'd0, cpu_run}, {31'd0, expOk});
    chk("error", {31'd0, error}, {31'd0, !expOk});
    @(negedge clk);
    #1;
    chk("sbEmpty", sb.size(), 32'd0);
    chk("doneHold", {31'd0, done}, {31'd0, expOk});
    chk("idleRdy", {31'd0, in_ready}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    load_start = 1'b1;
    in_valid   = 1'b0;
    in_byte    = 8'h00;
    repeat (2) @(negedge clk);
    load_start = 1'b0;
    chk("rstRun", {31'd0, cpu_run}, 32'd0);
    chk("rstDone", {31'd0, done}, 32'd0);
    chk("rstErr", {31'd0, error}, 32'd0);
    chk("rstRdy", {31'd0, in_ready}, 32'd0);
    chk("rstWr", {31'd0, wr_en}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("postRstRdy", {31'd0, in_ready}, 32'd0);

    // Two-word frame, bytes presented back to back.
    words = '{32'h8C010004, 32'h00221820};
    runFrame(8'd2, 1'b0, 1'b0, 1'b1);

    // Oversized count byte rejects the frame.
    startFrame();
    sendByte(8'h21, 1'b0);
    repeat (2) @(negedge clk);
    chk("ovfErr", {31'd0, error}, 32'd1);
    chk("ovfRun", {31'd0, cpu_run}, 32'd0);
    chk("ovfDone", {31'd0, done}, 32'd0);
    words = '{32'hCAFEF00D};
    runFrame(8'd1, 1'b0, 1'b0, 1'b1);

    // Count 0 loads the full memory, byte i = i.
    words = {};
    for (int w = 0; w < 32; w++) begin
      words.push_back({8'(4*w), 8'(4*w+1), 8'(4*w+2), 8'(4*w+3)});
    end
    runFrame(8'd0, 1'b0, 1'b0, 1'b1);

    // in_valid toggling every other cycle.
    words = '{32'h8C010004};
    runFrame(8'd1, 1'b1, 1'b0, 1'b1);

    // Asynchronous reset mid-frame, then a clean frame.
    startFrame();
    sendByte(8'd1, 1'b0);
    sendByte(8'hAA, 1'b0);
    sendByte(8'hBB, 1'b0);
    rst = 1'b1;
    #1;
    chk("arstRdy", {31'd0, in_ready}, 32'd0);
    chk("arstRun", {31'd0, cpu_run}, 32'd0);
    chk("arstDone", {31'd0, done}, 32'd0);
    chk("arstErr", {31'd0, error}, 32'd0);
    chk("arstWr", {31'd0, wr_en}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    words = '{32'h11223344};
    runFrame(8'd1, 1'b0, 1'b0, 1'b1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    words = '{32'h01020408};
    runFrame(8'd1, 1'b0, 1'b0, 1'b1);
    runFrame(8'd1, 1'b0, 1'b1, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
